// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the loopback FIFO: waits for full, settles, drains to empty,
// checks every word against an incrementing pattern and reports per-burst status.
module fifo_rd_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int DELAY_CYC = 10,
  parameter int START_VAL = 0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       rd_enable,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  input  logic [DATA_W-1:0]          fifo_rd_data,
  output logic                       fifo_rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_data_vld,
  output logic [$clog2(DEPTH):0]     rd_cnt,
  output logic [15:0]                err_cnt,
  output logic                       burst_done,
  output logic                       burst_ok
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DLY_W = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(2 * DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(DELAY_CYC - 1);
  localparam logic [DATA_W-1:0] EXP_START = DATA_W'(START_VAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_F,
    S_DELAY,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DLY_W-1:0]   r_dly_cnt;
  logic               r_rd_pend;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_data_vld;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [15:0]        r_err_cnt;
  logic               r_mismatch;
  logic [DATA_W-1:0]  r_expected;
  logic               r_burst_done;
  logic               r_burst_ok;

  logic               w_start;
  logic               w_word_bad;
  logic [CNT_W-1:0]   w_rd_cnt_nxt;
  logic [15:0]        w_err_cnt_nxt;
  logic               w_mismatch_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (rd_enable)              w_state_nxt = S_WAIT_F;
      S_WAIT_F: if (fifo_full)              w_state_nxt = S_DELAY;
      S_DELAY:  if (r_dly_cnt == DLY_LAST)  w_state_nxt = S_READ;
      S_READ:   if (fifo_empty)             w_state_nxt = S_DRAIN;
      S_DRAIN:                              w_state_nxt = S_DONE;
      S_DONE:                               w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  // Settle counter restarts from zero on every entry into DELAY.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dly_cnt <= '0;
    end else if (r_state == S_WAIT_F) begin
      r_dly_cnt <= '0;
    end else if (r_state == S_DELAY) begin
      r_dly_cnt <= r_dly_cnt + 1'b1;
    end
  end

  // Combinational strobe so the read stops the same cycle empty is seen.
  assign fifo_rd_en = (r_state == S_READ) & ~fifo_empty;

  assign w_start    = (r_state == S_IDLE) & rd_enable;
  assign w_word_bad = r_rd_pend & (fifo_rd_data != r_expected);

  always_comb begin
    w_rd_cnt_nxt   = r_rd_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    w_mismatch_nxt = r_mismatch;
    if (w_start) begin
      w_rd_cnt_nxt   = '0;
      w_mismatch_nxt = 1'b0;
    end else if (r_rd_pend) begin
      if (r_rd_cnt != CNT_MAX) w_rd_cnt_nxt = r_rd_cnt + 1'b1;
      if (w_word_bad) begin
        w_mismatch_nxt = 1'b1;
        if (r_err_cnt != 16'hFFFF) w_err_cnt_nxt = r_err_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rd_pend     <= 1'b0;
      r_rd_data     <= '0;
      r_rd_data_vld <= 1'b0;
      r_rd_cnt      <= '0;
      r_err_cnt     <= '0;
      r_mismatch    <= 1'b0;
      r_expected    <= EXP_START;
      r_burst_done  <= 1'b0;
      r_burst_ok    <= 1'b0;
    end else begin
      r_rd_pend     <= fifo_rd_en;
      r_rd_data_vld <= r_rd_pend;
      r_rd_cnt      <= w_rd_cnt_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
      r_mismatch    <= w_mismatch_nxt;
      r_burst_done  <= (r_state == S_DRAIN);
      if (r_rd_pend) r_rd_data <= fifo_rd_data;
      // Expected pattern keeps advancing after a mismatch; there is no resync.
      if (w_start) begin
        r_expected <= EXP_START;
      end else if (r_rd_pend) begin
        r_expected <= r_expected + 1'b1;
      end
      // Registered on the DRAIN->DONE edge so it is valid alongside burst_done.
      if (r_state == S_DRAIN) begin
        r_burst_ok <= (w_rd_cnt_nxt == CNT_FULL) & ~w_mismatch_nxt;
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_data_vld = r_rd_data_vld;
  assign rd_cnt      = r_rd_cnt;
  assign err_cnt     = r_err_cnt;
  assign burst_done  = r_burst_done;
  assign burst_ok    = r_burst_ok;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a standard-mode FIFO model feeds the DUT, a scoreboard queue
// holds each word as it is popped and is compared when rd_data_vld returns it.
module tb_fifo_rd_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = 9;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              rd_enable;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld;
  logic [CNT_W-1:0]  rd_cnt;
  logic [15:0]       err_cnt;
  logic              burst_done;
  logic              burst_ok;

  always #5 sys_clk = ~sys_clk;

  fifo_rd_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_CYC(10), .START_VAL(0)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rd_enable    (rd_enable),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .rd_data      (rd_data),
    .rd_data_vld  (rd_data_vld),
    .rd_cnt       (rd_cnt),
    .err_cnt      (err_cnt),
    .burst_done   (burst_done),
    .burst_ok     (burst_ok)
  );

  // FIFO model: 1-cycle read latency, flags follow the registered word count.
  logic [7:0] mem [0:255];
  logic [7:0] m_rd_ptr = '0;
  logic [8:0] m_count  = '0;
  logic [7:0] m_dout   = '0;
  logic       ld_req   = 1'b0;
  int         ld_n     = 0;
  int         ld_bad_idx = -1;
  logic [7:0] ld_bad_val = '0;

  assign fifo_full    = (m_count == 9'd256);
  assign fifo_empty   = (m_count == 9'd0);
  assign fifo_rd_data = m_dout;

  always @(posedge sys_clk) begin
    if (ld_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == ld_bad_idx) ? ld_bad_val : 8'(i);
      m_rd_ptr <= '0;
      m_count  <= 9'(ld_n);
    end else if (fifo_rd_en && m_count != 0) begin
      m_dout   <= mem[m_rd_ptr];
      m_rd_ptr <= m_rd_ptr + 8'd1;
      m_count  <= m_count - 9'd1;
    end
  end

  typedef struct {
    logic [7:0] d;
    int         c;
  } sb_t;

  sb_t  sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_rd = 0;
  int   rd_empty_viol = 0;
  logic seen_first = 1'b0;
  int   first_cyc = -1;
  int   last_ok = 0, last_cnt = 0, last_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge sys_clk);
      cyc++;
      @(negedge sys_clk);
      if (rd_data_vld) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.d));
          check("rd_latency", 32'(cyc - e.c), 32'd2);
        end
      end
      if (fifo_rd_en) begin
        if (fifo_empty) begin
          rd_empty_viol++;
        end else begin
          sb_q.push_back('{mem[m_rd_ptr], cyc});
          n_rd++;
          if (!seen_first) begin
            seen_first = 1'b1;
            first_cyc  = cyc;
          end
        end
      end
      if (burst_done) begin
        n_done++;
        last_ok  = int'(burst_ok);
        last_cnt = int'(rd_cnt);
        last_err = int'(err_cnt);
      end
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic load(input int n, input int bad_idx, input logic [7:0] bad_val);
    ld_n       = n;
    ld_bad_idx = bad_idx;
    ld_bad_val = bad_val;
    ld_req     = 1'b1;
    tick();
    ld_req     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check({tag, "_vld"},   32'(rd_data_vld), 32'd0);
    check({tag, "_data"},  32'(rd_data), 32'd0);
    check({tag, "_cnt"},   32'(rd_cnt), 32'd0);
    check({tag, "_err"},   32'(err_cnt), 32'd0);
    check({tag, "_done"},  32'(burst_done), 32'd0);
    check({tag, "_ok"},    32'(burst_ok), 32'd0);
  endtask

  // One burst: fill, arm rd_enable briefly (dropping it mid-burst), optionally shrink
  // the FIFO to 40 words during the settle delay, then check the burst report.
  task automatic run_burst(input string tag, input int bad_idx, input logic [7:0] bad_val,
                           input bit shorten, input int exp_ok, input int exp_cnt,
                           input int exp_err);
    int start, n0, r0, i;
    load(256, bad_idx, bad_val);
    seen_first = 1'b0;
    first_cyc  = -1;
    start      = cyc;
    n0         = n_done;
    r0         = n_rd;
    rd_enable  = 1'b1;
    repeat (3) tick();
    rd_enable  = 1'b0;
    if (shorten) load(40, -1, 8'h00);
    i = 0;
    while (n_done == n0 && i < 3000) begin
      tick();
      i++;
    end
    check({tag, "_done"},      32'(n_done - n0), 32'd1);
    check({tag, "_first_rd"},  32'(first_cyc - start), 32'd12);
    check({tag, "_reads"},     32'(n_rd - r0), 32'(exp_cnt));
    check({tag, "_rd_cnt"},    32'(last_cnt), 32'(exp_cnt));
    check({tag, "_burst_ok"},  32'(last_ok), 32'(exp_ok));
    check({tag, "_err_cnt"},   32'(last_err), 32'(exp_err));
    repeat (5) tick();
    check({tag, "_done_once"}, 32'(n_done - n0), 32'd1);
    check({tag, "_sb_empty"},  32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int r0, n0, i;
    sys_rst   = 1'b1;
    rd_enable = 1'b0;
    fork
      monitor();
    join_none
    repeat (5) tick();
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    tick();

    run_burst("clean",     -1,  8'h00, 1'b0, 1, 256, 0);
    run_burst("corrupt",   100, 8'hAA, 1'b0, 0, 256, 1);
    run_burst("recover",   -1,  8'h00, 1'b0, 1, 256, 1);
    run_burst("wrap_a",    -1,  8'h00, 1'b0, 1, 256, 1);
    run_burst("wrap_b",    -1,  8'h00, 1'b0, 1, 256, 1);

    // Reset while reading word 37: reads stop, outputs clear, FIFO keeps its words.
    load(256, -1, 8'h00);
    n0 = n_done;
    r0 = n_rd;
    rd_enable = 1'b1;
    repeat (3) tick();
    rd_enable = 1'b0;
    i = 0;
    while ((n_rd - r0) < 37 && i < 500) begin
      tick();
      i++;
    end
    check("midrst_reached_37", 32'(n_rd - r0), 32'd37);
    sys_rst = 1'b1;
    tick();
    sb_q.delete();
    check_reset_outputs("midrst");
    repeat (4) tick();
    sys_rst = 1'b0;
    r0 = n_rd;
    repeat (50) tick();
    check("midrst_no_reads",  32'(n_rd - r0), 32'd0);
    check("midrst_no_done",   32'(n_done - n0), 32'd0);
    check("midrst_fifo_kept", 32'(m_count), 32'd219);

    run_burst("short",     -1,  8'h00, 1'b1, 0, 40, 0);

    // rd_enable low with a full FIFO: the controller must stay idle.
    load(256, -1, 8'h00);
    r0 = n_rd;
    n0 = n_done;
    repeat (1000) tick();
    check("idle_no_reads", 32'(n_rd - r0), 32'd0);
    check("idle_no_done",  32'(n_done - n0), 32'd0);
    check("idle_fifo_full", 32'(fifo_full), 32'd1);
    check("no_read_while_empty", 32'(rd_empty_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
